// File: rtl/spsram_arb_pkg.sv
// spsram_arb_pkg: shared types and helpers for the single-port SRAM arbiter.
// Contents: requester-id type, response-tracking stage struct, default read latency,
//           and a modulo-increment helper used by the pointer logic.
package spsram_arb_pkg;

   // The id type is sized for the largest supported requester count (16).
   // Smaller arbiters zero-extend their narrower winner index into it.
   localparam int MAX_N   = 16;
   localparam int ID_W    = (MAX_N > 2) ? $clog2(MAX_N) : 1;
   localparam int DEF_LAT = 1;

   typedef logic [ID_W-1:0] req_id_t;

   // One stage of the read-response tracking pipeline.
   typedef struct packed {
      logic    vld;
      req_id_t id;
   } trk_t;

   // (v + 1) mod n for 0 <= v < n.
   function automatic int wrap_inc(input int v, input int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, one-hot grant to the first set bit of
//          req_i searching from ptr_i upward with wrap-around. Latency: 0 cycles.
// Backpressure: none; the caller decides when a grant is consumed.
// Ports: req_i (request bits), ptr_i (search start index), gnt_o (one-hot grant, 0 if no request).
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = (N > 2) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o
);

   logic [N-1:0] req_rot;
   logic [N-1:0] gnt_rot;

   // Rotate so that ptr_i lands on bit 0, isolate the lowest set bit, rotate back.
   // Doubling the vector makes the rotate a plain shift for any N, power of two or not.
   assign req_rot = N'({req_i, req_i} >> ptr_i);
   assign gnt_rot = req_rot & (~req_rot + {{(N-1){1'b0}}, 1'b1});
   assign gnt_o   = N'(({gnt_rot, gnt_rot} << ptr_i) >> N);

endmodule

// File: rtl/spsram_arb.sv
// spsram_arb: round-robin share of one single-port SRAM among N requesters.
// Latency: accept is combinational; read data returns exactly LAT cycles after accept.
// Backpressure: requesters hold until req_acpt; responses have none and must be sunk.
// Ports: clk/rst (sync active-high); req_vld/req_wr/req_addr/req_wdata in, req_acpt out;
//        rsp_vld/rsp_rdata out; sram_en/sram_wen/sram_addr/sram_din out, sram_dout in.
// Option: define SPSRAM_ARB_BURST_EN to let a winner keep priority for up to BURST_LEN
//         consecutive grants while it stays valid.
module spsram_arb
   import spsram_arb_pkg::*;
#(
   parameter int N         = 4,
   parameter int W         = 32,
   parameter int AW        = 10,
   parameter int LAT       = DEF_LAT,
   parameter int BURST_LEN = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req_vld,
   input  logic [N-1:0]    req_wr,
   input  logic [N*AW-1:0] req_addr,
   input  logic [N*W-1:0]  req_wdata,
   output logic [N-1:0]    req_acpt,
   output logic [N-1:0]    rsp_vld,
   output logic [W-1:0]    rsp_rdata,
   output logic            sram_en,
   output logic            sram_wen,
   output logic [AW-1:0]   sram_addr,
   output logic [W-1:0]    sram_din,
   input  logic [W-1:0]    sram_dout
);

   localparam int PW = (N > 2) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] ptr_inc;
   logic [N-1:0]  gnt;
   logic          any_gnt;
   logic [PW-1:0] win_id;
   trk_t          trk_q [LAT];
   trk_t          trk_in;
   trk_t          trk_last;

   rr_pick #(.N(N), .PW(PW)) u_pick (
      .req_i (req_vld),
      .ptr_i (ptr_q),
      .gnt_o (gnt)
   );

   assign any_gnt  = |req_vld;
   assign req_acpt = gnt;
   assign sram_en  = any_gnt;

   // Winner mux; gnt is one-hot or zero, so an idle cycle drives all zeros.
   always_comb begin
      win_id    = '0;
      sram_wen  = 1'b0;
      sram_addr = '0;
      sram_din  = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt[i]) begin
            win_id    = PW'(i);
            sram_wen  = req_wr[i];
            sram_addr = req_addr[i*AW +: AW];
            sram_din  = req_wdata[i*W +: W];
         end
      end
   end

   assign ptr_inc = PW'(wrap_inc(int'(win_id), N));

`ifdef SPSRAM_ARB_BURST_EN
   localparam int CW = $clog2(BURST_LEN + 1);

   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [PW-1:0] ptr_wrap;

   assign ptr_wrap = PW'(wrap_inc(int'(ptr_q), N));

   // While a burst is running ptr stays on the holder, so rr_pick naturally re-grants it.
   // A grant to anyone else (holder dropped) starts a fresh burst of length 1.
   always_comb begin
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      cnt_inc = ((win_id == ptr_q) && (cnt_q != '0)) ? cnt_q + CW'(1) : CW'(1);
      if (any_gnt) begin
         if (cnt_inc == CW'(BURST_LEN)) begin
            ptr_d = ptr_inc;
            cnt_d = '0;
         end else begin
            ptr_d = win_id;
            cnt_d = cnt_inc;
         end
      end else if (cnt_q != '0) begin
         // Holder went idle with nobody else asking: release it.
         ptr_d = ptr_wrap;
         cnt_d = '0;
      end
   end
`else
   always_comb begin
      ptr_d = any_gnt ? ptr_inc : ptr_q;
   end
`endif

   // Stage 0 records accepted reads only; writes produce no response.
   always_comb begin
      trk_in     = '0;
      trk_in.vld = any_gnt & ~sram_wen;
      trk_in.id  = req_id_t'(win_id);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
`ifdef SPSRAM_ARB_BURST_EN
         cnt_q <= '0;
`endif
         for (int s = 0; s < LAT; s++) begin
            trk_q[s] <= '0;
         end
      end else begin
         ptr_q <= ptr_d;
`ifdef SPSRAM_ARB_BURST_EN
         cnt_q <= cnt_d;
`endif
         trk_q[0] <= trk_in;
         for (int s = 1; s < LAT; s++) begin
            trk_q[s] <= trk_q[s-1];
         end
      end
   end

   // Masking with rst keeps a response that falls in the reset cycle itself from
   // escaping, so every read in flight at reset is dropped.
   assign trk_last  = trk_q[LAT-1];
   assign rsp_vld   = (trk_last.vld && !rst) ? ({{(N-1){1'b0}}, 1'b1} << trk_last.id) : '0;
   assign rsp_rdata = (trk_last.vld && !rst) ? sram_dout : '0;

endmodule
